// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// The WIDTH-bit carry chain is cut into STAGES slices of SLICE = WIDTH/STAGES
// bits. Each stage adds one slice, using the carry registered by the stage in
// front of it. Operand bits that are not yet added travel with the beat, and
// so do result bits that are already done. The whole pipeline advances
// together: it shifts when the output register is empty or is being drained.
// Otherwise every stage holds.
//
// Parameters
//   WIDTH   operand/result width; must be divisible by STAGES
//   STAGES  number of pipeline stages, 1..WIDTH (latency in cycles)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; drops all in-flight beats
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational from out_valid/out_ready)
//   a, b       operands
//   cin        carry into bit 0
//   sub        1: add with b inverted (use cin=1 for a-b)
//   out_valid  result valid
//   out_ready  consumer takes the result this cycle
//   sum        result bits
//   cout       carry out of bit WIDTH-1 (for a-b: 1 = no borrow)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module adder_pipe_nbit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Pipeline registers, one entry per stage.
    logic [STAGES-1:0] v_q;              // stage holds a live beat
    logic [STAGES-1:0] c_q;              // carry out of the slice this stage added
    logic [WIDTH-1:0]  a_q [STAGES];     // operand A carried forward
    logic [WIDTH-1:0]  b_q [STAGES];     // effective operand B carried forward
    logic [WIDTH-1:0]  s_q [STAGES];     // partial result, low slices complete
    logic              ovf_q;

    // Stage inputs and next-state values.
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_next;
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  s_in   [STAGES];
    logic [WIDTH-1:0]  s_next [STAGES];
    logic              ovf_next;

    logic              adv;
    logic [WIDTH-1:0]  beff;

    // The whole pipeline moves as one, so a stall at the output freezes
    // every stage. in_ready never depends on in_valid.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign beff     = sub ? ~b : b;

    // Stage 0 takes the ports directly. Every later stage takes the
    // registers of the stage in front of it.
    always_comb begin
        // NOTE: every variable gets a value on every path through an
        //       always_comb; a path that skips one would infer a latch.
        v_in    = '0;
        c_in    = '0;
        a_in[0] = a;
        b_in[0] = beff;
        s_in[0] = '0;
        v_in[0] = in_valid;
        c_in[0] = cin;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    // Each stage adds only its own slice. The carry out of the slice goes
    // to the next stage.
    always_comb begin
        logic [SLICE:0] slice_add;
        slice_add = '0;
        c_next    = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_add = {1'b0, a_in[k][k*SLICE +: SLICE]}
                      + {1'b0, b_in[k][k*SLICE +: SLICE]}
                      + {{SLICE{1'b0}}, c_in[k]};
            s_next[k]                  = s_in[k];
            s_next[k][k*SLICE +: SLICE] = slice_add[SLICE-1:0];
            c_next[k]                  = slice_add[SLICE];
        end
    end

    // Signed overflow: the operands have the same sign and the sign of the
    // result differs from it. The last stage still carries the operand sign
    // bits.
    assign ovf_next = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
                   && (s_next[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are cleared here as well as the valid
            //       bits. The outputs then start from a known value instead
            //       of X when bubbles shift through after reset.
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking assignments make every stage sample the
            //       value its neighbour held before this edge. That is what
            //       makes the registers behave as a shift pipeline.
            v_q   <= v_in;
            c_q   <= c_next;
            ovf_q <= ovf_next;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_next[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    // No stage reads the operand copies in the last stage, because every
    // slice has been added by then.
    logic unused_tail;
    assign unused_tail = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_nbit
//
// Runs three adder_pipe_nbit instances (STAGES = 4, 1, 8; WIDTH = 32) one at
// a time. Results are compared against a reference that treats the operation
// as plain integer arithmetic: an unsigned sum for {cout,sum}, and a signed
// range check for ovf. A queue keeps accepted beats in order.
// -----------------------------------------------------------------------------
module tb_adder_pipe_nbit;

    localparam int W  = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic         in_valid_v  [NI];
    logic         in_ready_v  [NI];
    logic         cin_v       [NI];
    logic         sub_v       [NI];
    logic         out_valid_v [NI];
    logic         out_ready_v [NI];
    logic         cout_v      [NI];
    logic         ovf_v       [NI];
    logic [W-1:0] a_v         [NI];
    logic [W-1:0] b_v         [NI];
    logic [W-1:0] sum_v       [NI];

    int stages_of [NI] = '{4, 1, 8};
    int pat       [8]  = '{1, 1, 0, 0, 0, 1, 0, 1};

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results in acceptance order: {ovf, cout, sum}.
    logic [W+1:0] exp_q [$];
    int           n_rx;
    logic         stalled;
    logic [W+1:0] held;

    always #5 clk = ~clk;

    adder_pipe_nbit #(.WIDTH(W), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    adder_pipe_nbit #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    adder_pipe_nbit #(.WIDTH(W), .STAGES(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    // Reference: integer addition. Overflow means the signed value of
    // a + beff + cin falls outside the signed W-bit range.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input logic s);
        logic [W-1:0] beff;
        logic [W:0]   full;
        longint       sval;
        logic         v;
        beff = s ? ~y : y;
        full = {1'b0, x} + {1'b0, beff} + {{W{1'b0}}, c};
        sval = longint'($signed(x)) + longint'($signed(beff)) + longint'(c);
        v    = (sval > longint'(32'sh7FFF_FFFF)) || (sval < -longint'(64'h8000_0000));
        return {v, full};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int i);
        in_valid_v[i]  = 1'b0;
        out_ready_v[i] = 1'b1;
        a_v[i]         = '0;
        b_v[i]         = '0;
        cin_v[i]       = 1'b0;
        sub_v[i]       = 1'b0;
    endtask

    // Sends one beat into an empty pipeline with out_ready held high. It
    // returns the result and the number of cycles until out_valid appeared
    // (0 if the result never appeared).
    task automatic run_one(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input logic s,
                           output logic [W+1:0] res, output int lat);
        @(negedge clk);
        in_valid_v[i] = 1'b1; a_v[i] = x; b_v[i] = y; cin_v[i] = c; sub_v[i] = s;
        out_ready_v[i] = 1'b1;
        #1;
        check($sformatf("accept_ready[%0d]", i), 64'(in_ready_v[i]), 64'd1);
        lat = 0;
        res = '0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            in_valid_v[i] = 1'b0;
            if (out_valid_v[i]) begin
                lat = cyc;
                res = {ovf_v[i], cout_v[i], sum_v[i]};
                break;
            end
        end
    endtask

    // Single-beat check against the reference, including latency.
    task automatic one_beat(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s, output logic [W+1:0] res);
        int lat;
        logic [W+1:0] e;
        run_one(i, x, y, c, s, res, lat);
        e = ref_model(x, y, c, s);
        check($sformatf("latency[%0d]", i), 64'(lat), 64'(stages_of[i]));
        check($sformatf("result[%0d]", i), 64'(res), 64'(e));
    endtask

    // One streaming cycle. Drive the inputs, work out the handshakes before
    // the coming edge, and score any result that drains.
    task automatic step(input int i, input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic ordy, output logic acc);
        logic [W+1:0] e;
        @(negedge clk);
        if (stalled) begin
            check("hold_valid", 64'(out_valid_v[i]), 64'd1);
            check("hold_data", 64'({ovf_v[i], cout_v[i], sum_v[i]}), 64'(held));
        end
        in_valid_v[i] = iv; a_v[i] = x; b_v[i] = y; cin_v[i] = c; sub_v[i] = s;
        out_ready_v[i] = ordy;
        #1;
        check("in_ready", 64'(in_ready_v[i]), 64'(!(out_valid_v[i] && !ordy)));
        if (out_valid_v[i] && ordy) begin
            check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stream_sum",  64'(sum_v[i]),  64'(e[W-1:0]));
                check("stream_cout", 64'(cout_v[i]), 64'(e[W]));
                check("stream_ovf",  64'(ovf_v[i]),  64'(e[W+1]));
                n_rx++;
            end
        end
        acc = iv && in_ready_v[i];
        if (acc) exp_q.push_back(ref_model(x, y, c, s));
        stalled = out_valid_v[i] && !ordy;
        held    = {ovf_v[i], cout_v[i], sum_v[i]};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+1:0] res;
        int           lat;
        int           sent;
        logic         acc;

        for (int i = 0; i < NI; i++) idle(i);
        rst_n   = 1'b0;
        stalled = 1'b0;
        n_rx    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state of every instance.
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_out_valid[%0d]", i), 64'(out_valid_v[i]), 64'd0);
            check($sformatf("rst_sum[%0d]", i), 64'(sum_v[i]), 64'd0);
            check($sformatf("rst_cout[%0d]", i), 64'(cout_v[i]), 64'd0);
            check($sformatf("rst_ovf[%0d]", i), 64'(ovf_v[i]), 64'd0);
            check($sformatf("rst_in_ready[%0d]", i), 64'(in_ready_v[i]), 64'd1);
        end

        // Carry rippling through every slice.
        run_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, res, lat);
        check("t1_sum", 64'(res[W-1:0]), 64'h0);
        check("t1_cout", 64'(res[W]), 64'd1);
        check("t1_ovf", 64'(res[W+1]), 64'd0);
        check("t1_latency", 64'(lat), 64'd4);

        // Subtraction with and without borrow.
        run_one(0, 32'd5, 32'd7, 1'b1, 1'b1, res, lat);
        check("t2a_sum", 64'(res[W-1:0]), 64'hFFFF_FFFE);
        check("t2a_cout", 64'(res[W]), 64'd0);
        check("t2a_ovf", 64'(res[W+1]), 64'd0);
        run_one(0, 32'd7, 32'd5, 1'b1, 1'b1, res, lat);
        check("t2b_sum", 64'(res[W-1:0]), 64'h2);
        check("t2b_cout", 64'(res[W]), 64'd1);

        // Signed overflow in both directions.
        run_one(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, res, lat);
        check("t3a_sum", 64'(res[W-1:0]), 64'h8000_0000);
        check("t3a_ovf", 64'(res[W+1]), 64'd1);
        check("t3a_cout", 64'(res[W]), 64'd0);
        run_one(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, res, lat);
        check("t3b_sum", 64'(res[W-1:0]), 64'h7FFF_FFFF);
        check("t3b_ovf", 64'(res[W+1]), 64'd1);

        // Backpressure and ordering: 16 beats under a fixed out_ready pattern.
        exp_q.delete();
        n_rx    = 0;
        sent    = 0;
        stalled = 1'b0;
        for (int t = 0; t < 400 && !(sent == 16 && n_rx == 16); t++) begin
            step(0, sent < 16, 32'(sent), 32'(sent) << 8, 1'b0, 1'b0, pat[t % 8] != 0, acc);
            if (acc) sent++;
        end
        check("t4_received", 64'(n_rx), 64'd16);
        check("t4_leftover", 64'(exp_q.size()), 64'd0);
        idle(0);

        // Reset in the middle of a stream: none of the three beats may appear.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1; a_v[0] = 32'(100 + k); b_v[0] = 32'(k);
            out_ready_v[0] = 1'b1;
            #1;
            check("t5_accept", 64'(in_ready_v[0]), 64'd1);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_valid_after_rst", 64'(out_valid_v[0]), 64'd0);
        check("t5_sum_after_rst", 64'(sum_v[0]), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_no_stale", 64'(out_valid_v[0]), 64'd0);
        end
        one_beat(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, res);

        // Parameter sweep: latency first, then a random stream with random
        // in_valid and out_ready.
        for (int i = 0; i < NI; i++) begin
            one_beat(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res);
            exp_q.delete();
            n_rx    = 0;
            sent    = 0;
            stalled = 1'b0;
            for (int t = 0; t < 12000 && !(sent == 1000 && n_rx == 1000); t++) begin
                step(i, (sent < 1000) && ($urandom_range(0, 3) != 0),
                     $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), acc);
                if (acc) sent++;
            end
            check($sformatf("sweep_received[%0d]", i), 64'(n_rx), 64'd1000);
            check($sformatf("sweep_leftover[%0d]", i), 64'(exp_q.size()), 64'd0);
            idle(i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised pipelined ripple-carry adder/subtractor with valid/ready flow control.
- Generalises the team's fixed 8-bit combinational adder to arbitrary WIDTH.
- The carry chain is split into STAGES registered slices, so wide adds close timing at full clock rate.
- Sits between operand-producing datapath units and downstream consumers that may apply backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages. Each stage adds one slice of SLICE = WIDTH/STAGES bits. Legal range is 1..WIDTH.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sub  input  1  0 = add, 1 = add with B inverted.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Reset is sampled at the rising edge of clk when rst_n=0; it is one clock, synchronous and active-low.
  - Clears every stage valid bit.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after rst_n returns to 1.
  - Reset mid-operation discards all in-flight beats; none are ever emitted.
- Arithmetic:
  - beff = sub ? ~b : b.
  - Result is {cout,sum} = a + beff + cin, computed at WIDTH+1 bits.
  - Subtraction a-b requires sub=1 and cin=1. In that case cout=1 means no borrow.
  - ovf = (a[W-1] == beff[W-1]) && (sum[W-1] != a[W-1]).
- Pipeline:
  - Stage k (0..STAGES-1) adds slice bits [k*SLICE +: SLICE] of a and beff, using the carry registered by stage k-1. Stage 0 uses cin.
  - Unprocessed upper operand slices are carried forward in registers.
  - Completed lower result slices are carried forward in registers.
  - The final stage registers sum, cout and ovf.
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+STAGES-1, i.e. visible in cycle N+STAGES. Throughput is one beat per cycle.
- Handshake:
  - Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
  - Global advance: adv = !out_valid || out_ready. On adv, all stages shift by one. On !adv, all stages hold.
  - in_ready = adv, combinational from out_ready and out_valid. There is no combinational path from in_valid to out_valid.
  - Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
  - Outputs hold stable while out_valid && !out_ready.
  - sum, cout and ovf are don't-care when out_valid=0, but must not be X after reset.
- Ordering: results leave in acceptance order. No beat is duplicated or dropped under any out_ready pattern.
- STAGES=1: a single registered full-width add with latency 1 and identical handshake behaviour.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both honoured.
  - rst_n=0 overrides all handshakes in that cycle.

Test Plan:
1. Carry across all slices: WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1.
   - Required: sum=0x00000000, cout=1, ovf=0.
   - Required: out_valid is asserted in exactly the 4th cycle after accept.
2. Subtract with borrow: a=5, b=7, sub=1, cin=1.
   - Required: sum=0xFFFFFFFE, cout=0, ovf=0.
   - Same set-up with a=7, b=5: sum=0x00000002, cout=1.
3. Signed overflow:
   - a=0x7FFFFFFF + b=0x00000001 gives sum=0x80000000, ovf=1, cout=0.
   - a=0x80000000 - b=0x00000001 (sub=1, cin=1) gives sum=0x7FFFFFFF, ovf=1.
4. Backpressure and ordering: stream 16 beats with a=i, b=i<<8 while out_ready follows 1,1,0,0,0,1,0,1,...
   - Required: all 16 results a+b are emitted in order with no loss.
   - Required: in_ready=0 exactly when out_valid=1 and out_ready=0.
   - Required: held outputs stay unchanged while stalled.
5. Reset mid-flight: accept 3 beats, then drive rst_n=0 for one edge.
   - Required: out_valid=0 from the following cycle; no stale beat is ever emitted.
   - Required: the next beat after reset returns the correct result with latency 4.
6. Parameter sweep: STAGES=1 and STAGES=8, both with WIDTH=32. Add a random 1000-beat stream with random in_valid/out_ready.
   - Required: every result matches the reference model {cout,sum}=a+beff+cin and ovf per formula.
   - Required: latency equals STAGES.
